cva6_dmr_recovery_ctrl: RTL and testbench



---
 rtl/cheshire_pkg.sv | 32 +++
 rtl/cva6_dmr_pair_fsm.sv | 166 ++++++++++++++++
 rtl/cva6_dmr_recovery_ctrl.sv | 56 +++++
 tb/tb_cva6_dmr_recovery_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_pkg.sv
// Shared types for the CVA6 DMR recovery controller: per-pair state encoding,
// registered output bundle and the state-to-output decode.
package cheshire_pkg;

    localparam int unsigned ErrCntW = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        SETBACK = 3'd2,
        RESUME  = 3'd3,
        FAILED  = 3'd4
    } dmr_rec_state_e;

    typedef struct packed {
        logic bus_block;
        logic setback;
        logic recovering;
        logic failed;
    } dmr_rec_out_t;

    // Output levels that belong to a state; loaded alongside every state change.
    function automatic dmr_rec_out_t dmr_rec_outputs(input dmr_rec_state_e state);
        dmr_rec_out_t o;
        o.bus_block  = (state != IDLE);
        o.setback    = (state == SETBACK) || (state == FAILED);
        o.recovering = (state == DRAIN) || (state == SETBACK) || (state == RESUME);
        o.failed     = (state == FAILED);
        return o;
    endfunction

endpackage

// File: rtl/cva6_dmr_pair_fsm.sv
// Recovery sequencer for one lockstepped core pair: outstanding AXI tracking,
// drain/setback/resume sequencing, retry guard window and sticky failure.
module cva6_dmr_pair_fsm
    import cheshire_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned DrainTimeout   = 1024,
    parameter int unsigned SetbackCycles  = 4,
    parameter int unsigned GuardCycles    = 256,
    parameter int unsigned MaxRetries     = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_dmr_error,
    input  logic               i_aw_fire,
    input  logic               i_ar_fire,
    input  logic               i_b_fire,
    input  logic               i_r_last_fire,
    input  logic               i_clear,
    output logic               o_bus_block,
    output logic               o_setback,
    output logic               o_recovering,
    output logic               o_failed,
    output logic [ErrCntW-1:0] o_err_count
);

    localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
    localparam int unsigned SumW   = CntW + 2;
    localparam int unsigned DrainW = $clog2(DrainTimeout + 1);
    localparam int unsigned SbW    = (SetbackCycles > 1) ? $clog2(SetbackCycles) : 1;
    localparam int unsigned GuardW = (GuardCycles > 0) ? $clog2(GuardCycles + 1) : 1;
    localparam int unsigned RetryW = $clog2(MaxRetries + 2);

    dmr_rec_state_e      r_state;
    dmr_rec_out_t        r_out;
    logic [CntW-1:0]     r_cnt;
    logic                r_proto_err;
    logic [DrainW-1:0]   r_drain_tmr;
    logic [SbW-1:0]      r_sb_tmr;
    logic [GuardW-1:0]   r_guard;
    logic [RetryW-1:0]   r_retries;
    logic [ErrCntW-1:0]  r_err_cnt;

    logic [1:0]          w_inc;
    logic [1:0]          w_dec;
    logic [SumW-1:0]     w_up;
    logic [CntW-1:0]     w_cnt_next;
    logic                w_clamp;
    logic [RetryW-1:0]   w_retries_new;

    // Next outstanding count, clamped to [0, MaxOutstanding]; clamping marks a protocol error.
    always_comb begin
        w_inc      = 2'(i_aw_fire) + 2'(i_ar_fire);
        w_dec      = 2'(i_b_fire) + 2'(i_r_last_fire);
        w_up       = SumW'(r_cnt) + SumW'(w_inc);
        w_cnt_next = r_cnt;
        w_clamp    = 1'b0;
        if (w_up < SumW'(w_dec)) begin
            w_cnt_next = '0;
            w_clamp    = 1'b1;
        end else if ((w_up - SumW'(w_dec)) > SumW'(MaxOutstanding)) begin
            w_cnt_next = CntW'(MaxOutstanding);
            w_clamp    = 1'b1;
        end else begin
            w_cnt_next = CntW'(w_up - SumW'(w_dec));
        end
    end

    assign w_retries_new = (r_guard != '0) ? (r_retries + RetryW'(1)) : RetryW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (i_clear) begin
                r_proto_err <= 1'b0;
            end else if (w_clamp) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_out       <= '0;
            r_drain_tmr <= '0;
            r_sb_tmr    <= '0;
            r_guard     <= '0;
            r_retries   <= '0;
            r_err_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_guard != '0) begin
                        r_guard <= r_guard - GuardW'(1);
                    end
                    if (i_dmr_error) begin
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + ErrCntW'(1);
                        end
                        r_retries   <= w_retries_new;
                        r_drain_tmr <= '0;
                        if (w_retries_new > RetryW'(MaxRetries)) begin
                            r_state <= FAILED;
                            r_out   <= dmr_rec_outputs(FAILED);
                        end else begin
                            r_state <= DRAIN;
                            r_out   <= dmr_rec_outputs(DRAIN);
                        end
                    end
                end
                // An empty pipeline beats the timeout when both land on the same cycle.
                DRAIN: begin
                    if (r_proto_err) begin
                        r_state <= FAILED;
                        r_out   <= dmr_rec_outputs(FAILED);
                    end else if (w_cnt_next == '0) begin
                        r_sb_tmr <= '0;
                        r_state  <= SETBACK;
                        r_out    <= dmr_rec_outputs(SETBACK);
                    end else if (r_drain_tmr == DrainW'(DrainTimeout)) begin
                        r_state <= FAILED;
                        r_out   <= dmr_rec_outputs(FAILED);
                    end else begin
                        r_drain_tmr <= r_drain_tmr + DrainW'(1);
                    end
                end
                SETBACK: begin
                    if (r_sb_tmr == SbW'(SetbackCycles - 1)) begin
                        r_state <= RESUME;
                        r_out   <= dmr_rec_outputs(RESUME);
                    end else begin
                        r_sb_tmr <= r_sb_tmr + SbW'(1);
                    end
                end
                RESUME: begin
                    r_guard <= GuardW'(GuardCycles);
                    r_state <= IDLE;
                    r_out   <= dmr_rec_outputs(IDLE);
                end
                FAILED: begin
                    if (i_clear) begin
                        r_retries <= '0;
                        r_guard   <= '0;
                        r_state   <= IDLE;
                        r_out     <= dmr_rec_outputs(IDLE);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_out   <= dmr_rec_outputs(IDLE);
                end
            endcase
        end
    end

    assign o_bus_block  = r_out.bus_block;
    assign o_setback    = r_out.setback;
    assign o_recovering = r_out.recovering;
    assign o_failed     = r_out.failed;
    assign o_err_count  = r_err_cnt;

endmodule

// File: rtl/cva6_dmr_recovery_ctrl.sv
// DMR mismatch recovery controller: one independent sequencer per core pair,
// with a shared interrupt raised while any pair is in sticky failure.
module cva6_dmr_recovery_ctrl
    import cheshire_pkg::*;
#(
    parameter int unsigned NumPairs       = 1,
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned DrainTimeout   = 1024,
    parameter int unsigned SetbackCycles  = 4,
    parameter int unsigned GuardCycles    = 256,
    parameter int unsigned MaxRetries     = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPairs-1:0]               dmr_error_i,
    input  logic [NumPairs-1:0]               aw_fire_i,
    input  logic [NumPairs-1:0]               ar_fire_i,
    input  logic [NumPairs-1:0]               b_fire_i,
    input  logic [NumPairs-1:0]               r_last_fire_i,
    input  logic [NumPairs-1:0]               clear_i,
    output logic [NumPairs-1:0]               bus_block_o,
    output logic [NumPairs-1:0]               setback_o,
    output logic [NumPairs-1:0]               recovering_o,
    output logic [NumPairs-1:0]               failed_o,
    output logic                              irq_o,
    output logic [NumPairs-1:0][ErrCntW-1:0]  err_count_o
);

    for (genvar g = 0; g < NumPairs; g++) begin : gen_pair
        cva6_dmr_pair_fsm #(
            .MaxOutstanding (MaxOutstanding),
            .DrainTimeout   (DrainTimeout),
            .SetbackCycles  (SetbackCycles),
            .GuardCycles    (GuardCycles),
            .MaxRetries     (MaxRetries)
        ) u_pair (
            .i_clk         (clk_i),
            .i_rst         (rst_i),
            .i_dmr_error   (dmr_error_i[g]),
            .i_aw_fire     (aw_fire_i[g]),
            .i_ar_fire     (ar_fire_i[g]),
            .i_b_fire      (b_fire_i[g]),
            .i_r_last_fire (r_last_fire_i[g]),
            .i_clear       (clear_i[g]),
            .o_bus_block   (bus_block_o[g]),
            .o_setback     (setback_o[g]),
            .o_recovering  (recovering_o[g]),
            .o_failed      (failed_o[g]),
            .o_err_count   (err_count_o[g])
        );
    end

    // Interrupt mirrors the per-pair sticky failure flops.
    assign irq_o = |failed_o;

endmodule

// File: tb/tb_cva6_dmr_recovery_ctrl.sv
// Self-checking bench for cva6_dmr_recovery_ctrl: directed recovery timelines,
// escalation, and randomized drain traffic against a behavioural model.
module tb_cva6_dmr_recovery_ctrl;

    localparam int NP = 2;
    localparam int MO = 16;
    localparam int DT = 16;
    localparam int S  = 4;
    localparam int GC = 256;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0] dmr_error, aw_fire, ar_fire, b_fire, r_last_fire, clear;
    logic [NP-1:0] bus_block, setback, recovering, failed;
    logic          irq;
    logic [NP-1:0][7:0] err_count;

    int errors = 0;
    int checks = 0;
    int mdl_out [NP];
    int mdl_err [NP];

    always #5 clk = ~clk;

    cva6_dmr_recovery_ctrl #(
        .NumPairs(NP), .MaxOutstanding(MO), .DrainTimeout(DT),
        .SetbackCycles(S), .GuardCycles(GC), .MaxRetries(MR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .dmr_error_i(dmr_error), .aw_fire_i(aw_fire),
        .ar_fire_i(ar_fire), .b_fire_i(b_fire), .r_last_fire_i(r_last_fire),
        .clear_i(clear), .bus_block_o(bus_block), .setback_o(setback),
        .recovering_o(recovering), .failed_o(failed), .irq_o(irq),
        .err_count_o(err_count)
    );

    // Advance one cycle; the model sees the inputs presented during that cycle.
    task automatic step();
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                mdl_out[p] = 0;
            end else begin
                mdl_out[p] += int'(aw_fire[p]) + int'(ar_fire[p]) - int'(b_fire[p]) - int'(r_last_fire[p]);
                if (mdl_out[p] < 0) mdl_out[p] = 0;
                if (mdl_out[p] > MO) mdl_out[p] = MO;
            end
        end
        @(posedge clk);
        #1;
        dmr_error = '0; aw_fire = '0; ar_fire = '0; b_fire = '0; r_last_fire = '0; clear = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int sat_err(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; step(); step();
        checks++; if (bus_block !== '0) begin errors++; $display("FAIL reset bus_block: got %b expected 0", bus_block); end
        checks++; if (setback !== '0) begin errors++; $display("FAIL reset setback: got %b expected 0", setback); end
        checks++; if (recovering !== '0) begin errors++; $display("FAIL reset recovering: got %b expected 0", recovering); end
        checks++; if (failed !== '0) begin errors++; $display("FAIL reset failed: got %b expected 0", failed); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset irq: got %b expected 0", irq); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL reset err_count: got %h expected 0", err_count); end
        rst = 1'b0; step();
        checks++; if (bus_block !== '0) begin errors++; $display("FAIL post_reset bus_block: got %b expected 0", bus_block); end
    endtask

    task automatic test_clean_recovery();
        logic exp_bb, exp_sb;
        dmr_error[0] = 1'b1; mdl_err[0]++; step();
        for (int t = 1; t <= S + 4; t++) begin
            exp_bb = (t <= S + 2);
            exp_sb = (t >= 2) && (t <= S + 1);
            checks++; if (bus_block[0] !== exp_bb) begin errors++; $display("FAIL clean bus_block t=%0d: got %b expected %b", t, bus_block[0], exp_bb); end
            checks++; if (setback[0] !== exp_sb) begin errors++; $display("FAIL clean setback t=%0d: got %b expected %b", t, setback[0], exp_sb); end
            checks++; if (recovering[0] !== exp_bb) begin errors++; $display("FAIL clean recovering t=%0d: got %b expected %b", t, recovering[0], exp_bb); end
            checks++; if (bus_block[1] !== 1'b0) begin errors++; $display("FAIL clean other_pair t=%0d: got %b expected 0", t, bus_block[1]); end
            step();
        end
        checks++; if (err_count[0] !== 8'(mdl_err[0])) begin errors++; $display("FAIL clean err_count: got %0d expected %0d", err_count[0], mdl_err[0]); end
    endtask

    task automatic test_parallel();
        logic exp_bb, exp_sb;
        dmr_error = '1; mdl_err[0]++; mdl_err[1]++; step();
        for (int t = 1; t <= S + 3; t++) begin
            exp_bb = (t <= S + 2);
            exp_sb = (t >= 2) && (t <= S + 1);
            for (int p = 0; p < NP; p++) begin
                checks++; if (bus_block[p] !== exp_bb) begin errors++; $display("FAIL parallel bus_block p=%0d t=%0d: got %b expected %b", p, t, bus_block[p], exp_bb); end
                checks++; if (setback[p] !== exp_sb) begin errors++; $display("FAIL parallel setback p=%0d t=%0d: got %b expected %b", p, t, setback[p], exp_sb); end
            end
            step();
        end
        for (int p = 0; p < NP; p++) begin
            checks++; if (err_count[p] !== 8'(mdl_err[p])) begin errors++; $display("FAIL parallel err_count p=%0d: got %0d expected %0d", p, err_count[p], mdl_err[p]); end
        end
    endtask

    task automatic test_drain_wait();
        for (int i = 0; i < 3; i++) begin aw_fire[0] = 1'b1; step(); end
        dmr_error[0] = 1'b1; mdl_err[0]++; step();
        // 3 writes before the error plus one on the cycle the block rises.
        for (int t = 1; t <= 15; t++) begin
            checks++; if (bus_block[0] !== 1'b1) begin errors++; $display("FAIL drain_wait bus_block t=%0d: got %b expected 1", t, bus_block[0]); end
            checks++; if (setback[0] !== (t == 15)) begin errors++; $display("FAIL drain_wait setback t=%0d: got %b expected %b", t, setback[0], (t == 15)); end
            if (t == 1) aw_fire[0] = 1'b1;
            if (t == 4 || t == 8 || t == 11 || t == 14) b_fire[0] = 1'b1;
            step();
        end
        idle(4);
        checks++; if (bus_block[0] !== 1'b0) begin errors++; $display("FAIL drain_wait release: got %b expected 0", bus_block[0]); end
    endtask

    task automatic test_drain_timeout();
        ar_fire[0] = 1'b1; step();
        dmr_error[0] = 1'b1; mdl_err[0]++; step();
        for (int t = 1; t <= 17; t++) begin
            checks++; if (failed[0] !== 1'b0 || bus_block[0] !== 1'b1) begin errors++; $display("FAIL timeout early t=%0d: got failed=%b bb=%b expected failed=0 bb=1", t, failed[0], bus_block[0]); end
            step();
        end
        checks++; if ({failed[0], irq, setback[0], bus_block[0], recovering[0]} !== 5'b11110) begin errors++; $display("FAIL timeout entry: got f/irq/sb/bb/rec=%b expected 11110", {failed[0], irq, setback[0], bus_block[0], recovering[0]}); end
        clear[0] = 1'b1; step();
        checks++; if ({failed[0], irq, bus_block[0]} !== 3'b000) begin errors++; $display("FAIL timeout clear: got f/irq/bb=%b expected 000", {failed[0], irq, bus_block[0]}); end
        // Read still outstanding; its last beat lands exactly on the timeout cycle.
        dmr_error[0] = 1'b1; mdl_err[0]++; step();
        for (int t = 1; t <= 17; t++) begin
            checks++; if (setback[0] !== 1'b0 || failed[0] !== 1'b0) begin errors++; $display("FAIL timeout_tie early t=%0d: got sb=%b f=%b expected 0 0", t, setback[0], failed[0]); end
            if (t == 17) r_last_fire[0] = 1'b1;
            step();
        end
        checks++; if (setback[0] !== 1'b1 || failed[0] !== 1'b0) begin errors++; $display("FAIL timeout_tie: got sb=%b f=%b expected sb=1 f=0", setback[0], failed[0]); end
        idle(5);
        checks++; if (bus_block[0] !== 1'b0) begin errors++; $display("FAIL timeout_tie release: got %b expected 0", bus_block[0]); end
    endtask

    task automatic test_simultaneous_count();
        aw_fire[0] = 1'b1; step();
        aw_fire[0] = 1'b1; ar_fire[0] = 1'b1; b_fire[0] = 1'b1; r_last_fire[0] = 1'b1; step();
        dmr_error[0] = 1'b1; mdl_err[0]++; step();
        for (int t = 1; t <= 4; t++) begin
            checks++; if (setback[0] !== (t == 4)) begin errors++; $display("FAIL simultaneous setback t=%0d: got %b expected %b", t, setback[0], (t == 4)); end
            if (t == 3) b_fire[0] = 1'b1;
            step();
        end
        idle(4);
        checks++; if (bus_block[0] !== 1'b0) begin errors++; $display("FAIL simultaneous release: got %b expected 0", bus_block[0]); end
    endtask

    task automatic test_protocol_error();
        b_fire[1] = 1'b1; step();
        dmr_error[1] = 1'b1; mdl_err[1]++; step();
        checks++; if (bus_block[1] !== 1'b1 || failed[1] !== 1'b0) begin errors++; $display("FAIL proto drain: got bb=%b f=%b expected 1 0", bus_block[1], failed[1]); end
        step();
        checks++; if (failed[1] !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL proto failed: got f=%b irq=%b expected 1 1", failed[1], irq); end
        clear[1] = 1'b1; step();
        checks++; if (failed[1] !== 1'b0) begin errors++; $display("FAIL proto clear: got %b expected 0", failed[1]); end
        dmr_error[1] = 1'b1; mdl_err[1]++; step(); step();
        checks++; if (setback[1] !== 1'b1 || failed[1] !== 1'b0) begin errors++; $display("FAIL proto flag_cleared: got sb=%b f=%b expected 1 0", setback[1], failed[1]); end
        idle(S + 2);
        checks++; if (bus_block[1] !== 1'b0) begin errors++; $display("FAIL proto release: got %b expected 0", bus_block[1]); end
    endtask

    task automatic test_guard_expiry();
        for (int r = 0; r < 5; r++) begin
            dmr_error[0] = 1'b1; mdl_err[0]++; step();
            checks++; if (failed[0] !== 1'b0 || bus_block[0] !== 1'b1) begin errors++; $display("FAIL guard round=%0d entry: got f=%b bb=%b expected 0 1", r, failed[0], bus_block[0]); end
            step();
            checks++; if (setback[0] !== 1'b1) begin errors++; $display("FAIL guard round=%0d setback: got %b expected 1", r, setback[0]); end
            // Next error lands 300 cycles after RESUME, past the guard window.
            idle(S + 2 + 300 - 2);
        end
        checks++; if (err_count[0] !== 8'(mdl_err[0])) begin errors++; $display("FAIL guard err_count: got %0d expected %0d", err_count[0], mdl_err[0]); end
    endtask

    task automatic test_retry_escalation();
        for (int i = 0; i <= MR; i++) begin
            dmr_error[0] = 1'b1; mdl_err[0]++; step();
            if (i < MR) begin
                checks++; if (failed[0] !== 1'b0 || bus_block[0] !== 1'b1) begin errors++; $display("FAIL retry %0d entry: got f=%b bb=%b expected 0 1", i, failed[0], bus_block[0]); end
                idle(S + 2);
                checks++; if (bus_block[0] !== 1'b0 || recovering[0] !== 1'b0) begin errors++; $display("FAIL retry %0d release: got bb=%b rec=%b expected 0 0", i, bus_block[0], recovering[0]); end
                idle(16 - (S + 3));
            end
        end
        checks++; if ({failed[0], irq, bus_block[0], setback[0], recovering[0]} !== 5'b11110) begin errors++; $display("FAIL retry escalate: got f/irq/bb/sb/rec=%b expected 11110", {failed[0], irq, bus_block[0], setback[0], recovering[0]}); end
        for (int i = 0; i < 3; i++) begin dmr_error[0] = 1'b1; step(); end
        checks++; if (err_count[0] !== 8'(mdl_err[0]) || failed[0] !== 1'b1) begin errors++; $display("FAIL retry sticky: got cnt=%0d f=%b expected cnt=%0d f=1", err_count[0], failed[0], mdl_err[0]); end
        clear[0] = 1'b1; step();
        checks++; if (failed[0] !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL retry clear: got f=%b irq=%b expected 0 0", failed[0], irq); end
        dmr_error[0] = 1'b1; mdl_err[0]++; step();
        checks++; if (failed[0] !== 1'b0 || recovering[0] !== 1'b1) begin errors++; $display("FAIL retry after_clear: got f=%b rec=%b expected 0 1", failed[0], recovering[0]); end
        idle(S + 2);
    endtask

    task automatic test_random_drain();
        logic zero_seen, done;
        for (int it = 0; it < 4; it++) begin
            idle(300);
            for (int c = 0; c < 20; c++) begin
                if (mdl_out[1] < 4) begin
                    aw_fire[1] = 1'($urandom_range(0, 1));
                    ar_fire[1] = 1'($urandom_range(0, 1));
                end
                if (mdl_out[1] >= 1) b_fire[1] = 1'($urandom_range(0, 1));
                if (mdl_out[1] >= 2) r_last_fire[1] = 1'($urandom_range(0, 1));
                step();
            end
            dmr_error[1] = 1'b1; mdl_err[1]++;
            if (mdl_out[1] == 0) aw_fire[1] = 1'b1;
            step();
            zero_seen = 1'b0; done = 1'b0;
            for (int t = 1; t <= 20 && !done; t++) begin
                checks++; if (bus_block[1] !== 1'b1 || failed[1] !== 1'b0) begin errors++; $display("FAIL random it=%0d t=%0d: got bb=%b f=%b expected 1 0", it, t, bus_block[1], failed[1]); end
                checks++; if (setback[1] !== zero_seen) begin errors++; $display("FAIL random setback it=%0d t=%0d: got %b expected %b", it, t, setback[1], zero_seen); end
                if (zero_seen) begin
                    done = 1'b1;
                end else begin
                    b_fire[1] = (mdl_out[1] >= 1) && (($urandom_range(0, 1) == 1) || (t % 2 == 0));
                    r_last_fire[1] = (mdl_out[1] >= 1 + int'(b_fire[1])) && ($urandom_range(0, 1) == 1);
                    step();
                    zero_seen = (mdl_out[1] == 0);
                end
            end
            checks++; if (!done) begin errors++; $display("FAIL random it=%0d drain not observed within 20 cycles", it); end
            idle(S + 1);
            checks++; if (bus_block[1] !== 1'b0) begin errors++; $display("FAIL random release it=%0d: got %b expected 0", it, bus_block[1]); end
            checks++; if (err_count[1] !== 8'(mdl_err[1])) begin errors++; $display("FAIL random err_count it=%0d: got %0d expected %0d", it, err_count[1], mdl_err[1]); end
        end
    endtask

    task automatic test_err_saturation();
        int issued;
        issued = 0;
        for (int c = 0; c < 4000 && issued < 260; c++) begin
            if (failed[1]) begin
                clear[1] = 1'b1;
            end else if (!bus_block[1]) begin
                dmr_error[1] = 1'b1; issued++;
            end
            step();
        end
        mdl_err[1] = sat_err(mdl_err[1] + issued);
        checks++; if (issued < 260) begin errors++; $display("FAIL saturation only %0d errors issued within budget", issued); end
        checks++; if (err_count[1] !== 8'(mdl_err[1])) begin errors++; $display("FAIL saturation err_count: got %0d expected %0d", err_count[1], mdl_err[1]); end
        if (failed[1]) begin clear[1] = 1'b1; step(); end
    endtask

    task automatic test_reset_mid();
        dmr_error[0] = 1'b1; step(); step(); step();
        checks++; if (setback[0] !== 1'b1) begin errors++; $display("FAIL reset_mid pre setback: got %b expected 1", setback[0]); end
        rst = 1'b1; step();
        checks++; if ({bus_block, setback, recovering, failed, irq} !== '0) begin errors++; $display("FAIL reset_mid outputs: got %b expected 0", {bus_block, setback, recovering, failed, irq}); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_mid err_count: got %h expected 0", err_count); end
        rst = 1'b0; mdl_err[0] = 0; mdl_err[1] = 0; step();
        checks++; if (bus_block !== '0) begin errors++; $display("FAIL reset_mid after: got %b expected 0", bus_block); end
    endtask

    initial begin
        rst = 1'b1;
        dmr_error = '0; aw_fire = '0; ar_fire = '0; b_fire = '0; r_last_fire = '0; clear = '0;
        for (int p = 0; p < NP; p++) begin mdl_out[p] = 0; mdl_err[p] = 0; end
        test_reset();
        idle(10);
        test_clean_recovery();
        idle(300); test_parallel();
        idle(300); test_drain_wait();
        idle(300); test_drain_timeout();
        idle(300); test_simultaneous_count();
        idle(300); test_protocol_error();
        idle(300); test_guard_expiry();
        idle(300); test_retry_escalation();
        test_random_drain();
        idle(300); test_err_saturation();
        idle(300); test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
